// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared unit/function codes and FSM state encoding for alu_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // op[1:0] selects the execution unit
    localparam logic [1:0] ALU_ARITH = 2'b00;
    localparam logic [1:0] ALU_LOGIC = 2'b01;
    localparam logic [1:0] ALU_SHIFT = 2'b10;
    localparam logic [1:0] ALU_MUL   = 2'b11;

    // op[3:2] selects the function within a unit
    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_SUB = 2'b01;
    localparam logic [1:0] FN_INC = 2'b10;
    localparam logic [1:0] FN_DEC = 2'b11;

    localparam logic [1:0] FN_AND = 2'b00;
    localparam logic [1:0] FN_OR  = 2'b01;
    localparam logic [1:0] FN_XOR = 2'b10;
    localparam logic [1:0] FN_NOT = 2'b11;

    localparam logic [1:0] FN_SLL = 2'b00;
    localparam logic [1:0] FN_SRL = 2'b01;
    localparam logic [1:0] FN_SRA = 2'b10;
    localparam logic [1:0] FN_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
// Module      : alu_mul_seq
// Description : N-cycle signed shift-add multiplier, one multiplier bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N) + 1;

    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic [2*N-1:0] w_term;
    logic [2*N-1:0] w_acc_nxt;

    // The multiplier sign bit is consumed last and carries weight -2^(N-1).
    always_comb begin
        w_term = r_mplier[0] ? r_mcand : '0;
        if (!r_busy)
            w_acc_nxt = r_acc;
        else if (r_cnt == CW'(1))
            w_acc_nxt = r_acc - w_term;
        else
            w_acc_nxt = r_acc + w_term;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_acc    <= '0;
            r_mcand  <= {{N{A[N-1]}}, A};
            r_mplier <= B;
            r_cnt    <= CW'(N);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            r_busy   <= (r_cnt != CW'(1));
        end
    end

    // Exposes the post-step value so the final product is usable on the last step's edge.
    assign busy    = r_busy;
    assign product = w_acc_nxt;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle ALU with valid/ready handshakes, iterative shifter
//               and sequential signed multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] F,
    output logic [N-1:0] H,
    output logic         G,
    output logic         E,
    output logic         L,
    output logic         Zero,
    output logic         carryOut,
    output logic         Overflow
);

    localparam int SW = $clog2(N);
    localparam int CW = SW + 1;

    state_t         r_state;
    logic [N-1:0]   r_sh;
    logic [1:0]     r_fn;
    logic [CW-1:0]  r_cnt;
    logic           r_g, r_e, r_l;
    logic [N-1:0]   r_f, r_h;
    logic           r_gt, r_eq, r_lt, r_zero, r_co, r_ov;

    logic           w_accept;
    logic [SW-1:0]  w_k;
    logic [N-1:0]   w_b_eff;
    logic           w_cin;
    logic [N:0]     w_sum;
    logic [N-1:0]   w_logic;
    logic [N-1:0]   w_res;
    logic           w_co, w_ov, w_imm;
    logic           w_gt, w_eq, w_lt;
    logic [N-1:0]   w_sh_step;
    logic           w_mul_start, w_mul_busy;
    logic [2*N-1:0] w_prod;

    assign in_ready    = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign out_valid   = (r_state == DONE);
    assign w_accept    = in_valid & in_ready;
    assign w_k         = B[SW-1:0];
    assign w_mul_start = w_accept & (op[1:0] == ALU_MUL);
    assign w_gt        = $signed(A) > $signed(B);
    assign w_eq        = (A == B);
    assign w_lt        = $signed(A) < $signed(B);

    always_comb begin
        w_b_eff = B;
        w_cin   = 1'b0;
        case (op[3:2])
            FN_ADD: begin w_b_eff = B;   w_cin = 1'b0; end
            FN_SUB: begin w_b_eff = ~B;  w_cin = 1'b1; end
            FN_INC: begin w_b_eff = '0;  w_cin = 1'b1; end
            FN_DEC: begin w_b_eff = '1;  w_cin = 1'b0; end
        endcase
        w_sum = {1'b0, A} + {1'b0, w_b_eff} + {{N{1'b0}}, w_cin};

        w_logic = '0;
        case (op[3:2])
            FN_AND: w_logic = A & B;
            FN_OR:  w_logic = A | B;
            FN_XOR: w_logic = A ^ B;
            FN_NOT: w_logic = ~A;
        endcase

        // Shift by zero passes A through; the multiply path never uses these.
        w_res = A;
        w_co  = 1'b0;
        w_ov  = 1'b0;
        if (op[1:0] == ALU_ARITH) begin
            w_res = w_sum[N-1:0];
            w_co  = w_sum[N];
            w_ov  = (A[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != A[N-1]);
        end else if (op[1:0] == ALU_LOGIC) begin
            w_res = w_logic;
        end
        w_imm = (op[1:0] == ALU_ARITH) || (op[1:0] == ALU_LOGIC) ||
                ((op[1:0] == ALU_SHIFT) && (w_k == '0));
    end

    always_comb begin
        w_sh_step = r_sh;
        case (r_fn)
            FN_SLL: w_sh_step = {r_sh[N-2:0], 1'b0};
            FN_SRL: w_sh_step = {1'b0, r_sh[N-1:1]};
            FN_SRA: w_sh_step = {r_sh[N-1], r_sh[N-1:1]};
            FN_ROL: w_sh_step = {r_sh[N-2:0], r_sh[N-1]};
        endcase
    end

    alu_mul_seq #(.N(N)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .A       (A),
        .B       (B),
        .busy    (w_mul_busy),
        .product (w_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_fn    <= '0;
            r_cnt   <= '0;
            r_g     <= 1'b0;
            r_e     <= 1'b0;
            r_l     <= 1'b0;
            r_f     <= '0;
            r_h     <= '0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_zero  <= 1'b0;
            r_co    <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            case (r_state)
                SHIFT: begin
                    r_sh  <= w_sh_step;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= DONE;
                        r_f     <= w_sh_step;
                        r_h     <= '0;
                        r_zero  <= (w_sh_step == '0);
                        r_co    <= 1'b0;
                        r_ov    <= 1'b0;
                        r_gt    <= r_g;
                        r_eq    <= r_e;
                        r_lt    <= r_l;
                    end
                end
                MUL: begin
                    if (w_mul_busy) begin
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_state <= DONE;
                            r_f     <= w_prod[N-1:0];
                            r_h     <= w_prod[2*N-1:N];
                            r_zero  <= (w_prod == '0);
                            r_co    <= 1'b0;
                            r_ov    <= (w_prod != {{N{w_prod[N-1]}}, w_prod[N-1:0]});
                            r_gt    <= r_g;
                            r_eq    <= r_e;
                            r_lt    <= r_l;
                        end
                    end
                end
                DONE: begin
                    if (out_ready && !in_valid)
                        r_state <= IDLE;
                end
                default: ;
            endcase

            if (w_accept) begin
                r_sh <= A;
                r_fn <= op[3:2];
                r_g  <= w_gt;
                r_e  <= w_eq;
                r_l  <= w_lt;
                if (w_imm) begin
                    r_state <= DONE;
                    r_f     <= w_res;
                    r_h     <= '0;
                    r_zero  <= (w_res == '0);
                    r_co    <= w_co;
                    r_ov    <= w_ov;
                    r_gt    <= w_gt;
                    r_eq    <= w_eq;
                    r_lt    <= w_lt;
                end else if (op[1:0] == ALU_SHIFT) begin
                    r_state <= SHIFT;
                    r_cnt   <= {1'b0, w_k};
                end else begin
                    r_state <= MUL;
                    r_cnt   <= CW'(N);
                end
            end
        end
    end

    assign F        = r_f;
    assign H        = r_h;
    assign G        = r_gt;
    assign E        = r_eq;
    assign L        = r_lt;
    assign Zero     = r_zero;
    assign carryOut = r_co;
    assign Overflow = r_ov;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (N=8) against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

    localparam int N = 8;

    typedef struct {
        logic [N-1:0] f;
        logic [N-1:0] h;
        logic         g, e, l, z, c, v;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [3:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] F, H;
    logic         G, E, L, Zero, carryOut, Overflow;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F),
        .H         (H),
        .G         (G),
        .E         (E),
        .L         (L),
        .Zero      (Zero),
        .carryOut  (carryOut),
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] o);
        exp_t   r;
        int     sa, sb, ua, ub, k, s, sres, m;
        longint p;
        logic [2*N-1:0] pv;
        m  = 1 << N;
        sa = $signed(a);
        sb = $signed(b);
        ua = int'(a);
        ub = int'(b);
        k  = ub % N;
        r.f = '0; r.h = '0; r.c = 1'b0; r.v = 1'b0;
        r.g = (sa > sb);
        r.e = (sa == sb);
        r.l = (sa < sb);
        r.lat = 1;
        s = 0; sres = 0;
        case (o[1:0])
            2'b00: begin
                case (o[3:2])
                    2'b00: begin s = ua + ub;     sres = sa + sb; end
                    2'b01: begin s = ua + m - ub; sres = sa - sb; end
                    2'b10: begin s = ua + 1;      sres = sa + 1;  end
                    default: begin s = ua + m - 1; sres = sa - 1; end
                endcase
                r.f = N'(s % m);
                r.c = (s >= m);
                r.v = (sres > (m / 2 - 1)) || (sres < -(m / 2));
            end
            2'b01: begin
                case (o[3:2])
                    2'b00: r.f = a & b;
                    2'b01: r.f = a | b;
                    2'b10: r.f = a ^ b;
                    default: r.f = ~a;
                endcase
            end
            2'b10: begin
                case (o[3:2])
                    2'b00: r.f = N'((ua << k) % m);
                    2'b01: r.f = N'(ua >> k);
                    2'b10: r.f = N'(sa >>> k);
                    default: r.f = N'(((ua << k) | (ua >> (N - k))) % m);
                endcase
                r.lat = 1 + k;
            end
            default: begin
                p   = longint'(sa) * longint'(sb);
                pv  = p[2*N-1:0];
                r.f = pv[N-1:0];
                r.h = pv[2*N-1:N];
                r.v = (p > longint'(m / 2 - 1)) || (p < -longint'(m / 2));
                r.lat = N + 1;
            end
        endcase
        r.z = (r.f == '0) && (r.h == '0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t x);
        chk({tag, ".F"}, 64'(F), 64'(x.f));
        chk({tag, ".H"}, 64'(H), 64'(x.h));
        chk({tag, ".GEL"}, 64'({G, E, L}), 64'({x.g, x.e, x.l}));
        chk({tag, ".Zero"}, 64'(Zero), 64'(x.z));
        chk({tag, ".carry"}, 64'(carryOut), 64'(x.c));
        chk({tag, ".ovf"}, 64'(Overflow), 64'(x.v));
    endtask

    // Presents one request, returns right after its acceptance edge with inputs scrambled.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] o);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 200) chk("ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1; A = a; B = b; op = o;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = N'($urandom); B = N'($urandom); op = 4'($urandom);
    endtask

    task automatic wait_result(input string tag, input exp_t x);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(x.lat - 1));
        check_outputs(tag, x);
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] o);
        exp_t x;
        x = model(a, b, o);
        out_ready = 1'b1;
        issue(a, b, o);
        wait_result(tag, x);
        @(posedge clk); #1;
        chk({tag, ".released"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        exp_t x, hold;
        int   seen;

        #2;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        x = '{f: '0, h: '0, g: 1'b0, e: 1'b0, l: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0, lat: 0};
        check_outputs("rst", x);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        run_op("add", 8'd100, 8'd50, 4'b0000);
        run_op("sub", 8'd5, 8'd5, 4'b0100);
        run_op("sra", 8'h80, 8'd3, 4'b1010);
        run_op("rol", 8'h81, 8'd1, 4'b1110);
        run_op("sll0", 8'hA5, 8'd8, 4'b0010);
        run_op("mul_neg", 8'hFD, 8'd7, 4'b0011);
        run_op("mul_ovf", 8'd16, 8'd16, 4'b0011);
        run_op("mul_min", 8'h80, 8'h80, 4'b0011);
        run_op("dec", 8'h80, 8'h00, 4'b1100);
        run_op("not", 8'h5A, 8'h00, 4'b1101);

        // Backpressure hold, then back-to-back handshake.
        out_ready = 1'b0;
        hold = model(8'd100, 8'd50, 4'b0000);
        issue(8'd100, 8'd50, 4'b0000);
        wait_result("hold", hold);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold.valid", 64'(out_valid), 64'd1);
            chk("hold.in_ready", 64'(in_ready), 64'd0);
            check_outputs("hold", hold);
        end
        in_valid = 1'b1; A = 8'hF0; B = 8'h3C; op = 4'b0001; out_ready = 1'b1;
        #1;
        chk("b2b.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b.valid", 64'(out_valid), 64'd1);
        check_outputs("b2b", model(8'hF0, 8'h3C, 4'b0001));
        @(posedge clk); #1;

        // Reset during cycle 4 of a multiply.
        issue(8'hFD, 8'd7, 4'b0011);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("abort.out_valid", 64'(out_valid), 64'd0);
        chk("abort.in_ready", 64'(in_ready), 64'd1);
        x = '{f: '0, h: '0, g: 1'b0, e: 1'b0, l: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0, lat: 0};
        check_outputs("abort", x);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort.no_stale", 64'(seen), 64'd0);
        run_op("post_rst_add", 8'd1, 8'd1, 4'b0000);

        for (int i = 0; i < 60; i++)
            run_op("rand", N'($urandom), N'($urandom), 4'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
